// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the fetch port and the load/store data port onto
// one byte-addressed 16-bit synchronous memory and returns read data.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   f_req/f_addr         fetch request (always a wide read)
//   f_gnt                fetch accepted this cycle (combinational)
//   f_rvalid/f_rdata     fetch response, two cycles after grant
//   d_req/d_wr/d_wide    data request, store/load, 16/8-bit access
//   d_signed             narrow load sign extension select
//   d_addr/d_wdata       data byte address and store data
//   d_gnt                data accepted this cycle (combinational)
//   d_rvalid/d_rdata     load response, two cycles after grant
//   mem_en/mem_wr/mem_wide/mem_addr/mem_din   memory controls
//   mem_dout             memory read data, valid the cycle after mem_en
//
// Build option: define MEM_ARB_FAIR_EN to bound how long fetch can be
// starved by data traffic (FAIR_LIMIT consecutive data grants). Without
// it data always wins.
module mem_arbiter #(
   parameter int FAIR_LIMIT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        f_req,
   input  logic [15:0] f_addr,
   output logic        f_gnt,
   output logic        f_rvalid,
   output logic [15:0] f_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic        d_wide,
   input  logic        d_signed,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [15:0] d_rdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic        mem_wide,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout
);

   if (FAIR_LIMIT < 1 || FAIR_LIMIT > 15) begin : g_bad_limit
      $error("mem_arbiter: FAIR_LIMIT out of range 1..15");
   end

   // Per-access tag carried alongside the memory read.
   typedef struct packed {
      logic vld;
      logic port_d;
      logic rd;
      logic wide;
      logic sgn;
   } tag_t;

   tag_t        s1;
   tag_t        s1_nxt;
   logic [7:0]  rbyte;
   logic [15:0] rd_ext;
   logic        ret_f;
   logic        ret_d;

   // ------------------------------------------------------------------
   // Grant selection
   // ------------------------------------------------------------------
`ifdef MEM_ARB_FAIR_EN
   logic [3:0] fcnt;
   logic       f_force;

   // Fetch has waited through FAIR_LIMIT data grants: it goes next.
   assign f_force = f_req && (fcnt == 4'(FAIR_LIMIT));

   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (rst_n) begin
         if (f_req && (!d_req || f_force)) begin
            f_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fcnt <= 4'd0;
      end else if (!f_req || f_gnt) begin
         fcnt <= 4'd0;
      end else if (d_gnt) begin
         fcnt <= fcnt + 4'd1;
      end
   end
`else
   always_comb begin
      f_gnt = 1'b0;
      d_gnt = 1'b0;
      if (rst_n) begin
         if (d_req) begin
            d_gnt = 1'b1;
         end else if (f_req) begin
            f_gnt = 1'b1;
         end
      end
   end
`endif

   // ------------------------------------------------------------------
   // Memory drive: idle cycles park on the data-port fields
   // ------------------------------------------------------------------
   assign mem_en   = f_gnt | d_gnt;
   assign mem_wr   = d_gnt & d_wr;
   assign mem_wide = f_gnt ? 1'b1 : d_wide;
   assign mem_addr = f_gnt ? f_addr : d_addr;
   assign mem_din  = d_wdata;

   // ------------------------------------------------------------------
   // Stage 1 tag: only reads leave a tag, so stores never respond
   // ------------------------------------------------------------------
   always_comb begin
      s1_nxt = '0;
      if (d_gnt && !d_wr) begin
         s1_nxt.vld    = 1'b1;
         s1_nxt.port_d = 1'b1;
         s1_nxt.rd     = 1'b1;
         s1_nxt.wide   = d_wide;
         s1_nxt.sgn    = d_signed;
      end else if (f_gnt) begin
         s1_nxt.vld    = 1'b1;
         s1_nxt.port_d = 1'b0;
         s1_nxt.rd     = 1'b1;
         s1_nxt.wide   = 1'b1;
         s1_nxt.sgn    = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: format read data. Big-endian, so the addressed byte of a
   // narrow read sits in the upper half of mem_dout.
   // ------------------------------------------------------------------
   assign rbyte = mem_dout[15:8];
   assign ret_f = s1.vld & s1.rd & ~s1.port_d;
   assign ret_d = s1.vld & s1.rd & s1.port_d;

   always_comb begin
      rd_ext = mem_dout;
      if (!s1.wide) begin
         if (s1.sgn) begin
            rd_ext = {{8{rbyte[7]}}, rbyte};
         end else begin
            rd_ext = {8'h00, rbyte};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1       <= '0;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         f_rdata  <= 16'h0000;
         d_rdata  <= 16'h0000;
      end else begin
         s1       <= s1_nxt;
         f_rvalid <= ret_f;
         d_rvalid <= ret_d;
         if (ret_f) begin
            f_rdata <= rd_ext;
         end
         if (ret_d) begin
            d_rdata <= rd_ext;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a
// big-endian byte memory model behind it.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        f_req = 1'b0;
   logic [15:0] f_addr = 16'h0000;
   logic        f_gnt;
   logic        f_rvalid;
   logic [15:0] f_rdata;
   logic        d_req = 1'b0;
   logic        d_wr = 1'b0;
   logic        d_wide = 1'b0;
   logic        d_signed = 1'b0;
   logic [15:0] d_addr = 16'h0000;
   logic [15:0] d_wdata = 16'h0000;
   logic        d_gnt;
   logic        d_rvalid;
   logic [15:0] d_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic        mem_wide;
   logic [15:0] mem_addr;
   logic [15:0] mem_din;
   logic [15:0] mem_dout = 16'h0000;

   logic        bk_we = 1'b0;
   logic [15:0] bk_a = 16'h0000;
   logic [7:0]  bk_d = 8'h00;
   logic [7:0]  mem [0:65535];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory model: write at grant edge, read data registered one cycle.
   always @(posedge clk) begin
      if (bk_we) mem[bk_a] <= bk_d;
      if (mem_en && mem_wr) begin
         if (mem_wide) begin
            mem[mem_addr] <= mem_din[15:8];
            mem[mem_addr + 16'd1] <= mem_din[7:0];
         end else begin
            mem[mem_addr] <= mem_din[7:0];
         end
      end
      if (mem_en && !mem_wr)
         mem_dout <= {mem[mem_addr], mem[mem_addr + 16'd1]};
   end

   mem_arbiter #(.FAIR_LIMIT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
      .f_rvalid(f_rvalid), .f_rdata(f_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_wide(d_wide), .d_signed(d_signed),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_wide(mem_wide),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   task automatic set_idle();
      f_req = 1'b0;
      d_req = 1'b0;
      d_wr = 1'b0;
   endtask

   task automatic set_d(input logic wr, input logic wide, input logic sgn,
                        input logic [15:0] a, input logic [15:0] wd);
      d_req = 1'b1;
      d_wr = wr;
      d_wide = wide;
      d_signed = sgn;
      d_addr = a;
      d_wdata = wd;
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bk_we = 1'b1;
      bk_a = a;
      bk_d = d;
      @(negedge clk);
      bk_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      f_req = 1'b1;
      f_addr = 16'h0100;
      set_d(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (f_gnt !== 1'b0) begin errors++; $display("FAIL rst_f_gnt: got %b expected 0", f_gnt); end
      checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL rst_d_gnt: got %b expected 0", d_gnt); end
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
      checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL rst_f_rvalid: got %b expected 0", f_rvalid); end
      checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_d_rvalid: got %b expected 0", d_rvalid); end
      checks++; if (f_rdata !== 16'h0000) begin errors++; $display("FAIL rst_f_rdata: got %h expected 0000", f_rdata); end
      checks++; if (d_rdata !== 16'h0000) begin errors++; $display("FAIL rst_d_rdata: got %h expected 0000", d_rdata); end
      set_idle();
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %b expected 0", mem_en); end
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL idle_mem_wr: got %b expected 0", mem_wr); end
   endtask

   task automatic test_fetch();
      preload(16'h0100, 8'h12);
      preload(16'h0101, 8'h34);
      preload(16'h0102, 8'h56);
      @(negedge clk);
      f_req = 1'b1;
      f_addr = 16'h0100;
      #1;
      checks++; if (f_gnt !== 1'b1) begin errors++; $display("FAIL fetch_gnt: got %b expected 1", f_gnt); end
      checks++; if (d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_d_gnt: got %b expected 0", d_gnt); end
      checks++; if ({mem_en, mem_wr, mem_wide} !== 3'b101) begin errors++; $display("FAIL fetch_ctl: got %b expected 101", {mem_en, mem_wr, mem_wide}); end
      checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL fetch_addr: got %h expected 0100", mem_addr); end
      @(negedge clk);
      set_idle();
      #1;
      checks++; if ({f_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL fetch_t1_rvalid: got %b expected 00", {f_rvalid, d_rvalid}); end
      @(negedge clk);
      #1;
      checks++; if (f_rvalid !== 1'b1) begin errors++; $display("FAIL fetch_rvalid: got %b expected 1", f_rvalid); end
      checks++; if (f_rdata !== 16'h1234) begin errors++; $display("FAIL fetch_rdata: got %h expected 1234", f_rdata); end
      checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_d_rvalid: got %b expected 0", d_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse: got %b expected 0", f_rvalid); end
      checks++; if (f_rdata !== 16'h1234) begin errors++; $display("FAIL fetch_hold: got %h expected 1234", f_rdata); end
   endtask

   task automatic test_wide_load();
      @(negedge clk);
      set_d(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000);
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL wload_gnt: got %b expected 1", d_gnt); end
      checks++; if (mem_addr !== 16'h0101) begin errors++; $display("FAIL wload_addr: got %h expected 0101", mem_addr); end
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL wload_rvalid: got %b expected 1", d_rvalid); end
      checks++; if (d_rdata !== 16'h3456) begin errors++; $display("FAIL wload_rdata: got %h expected 3456", d_rdata); end
      checks++; if (f_rvalid !== 1'b0) begin errors++; $display("FAIL wload_f_rvalid: got %b expected 0", f_rvalid); end
      preload(16'hFFFF, 8'h9A);
      preload(16'h0000, 8'hBC);
      @(negedge clk);
      set_d(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL wrap_rvalid: got %b expected 1", d_rvalid); end
      checks++; if (d_rdata !== 16'h9ABC) begin errors++; $display("FAIL wrap_rdata: got %h expected 9abc", d_rdata); end
      checks++; if (f_rdata !== 16'h1234) begin errors++; $display("FAIL wrap_f_hold: got %h expected 1234", f_rdata); end
   endtask

   task automatic test_narrow();
      @(negedge clk);
      set_d(1'b1, 1'b0, 1'b0, 16'h0103, 16'h00AB);
      #1;
      checks++; if ({d_gnt, mem_wr, mem_wide} !== 3'b110) begin errors++; $display("FAIL nstore_ctl: got %b expected 110", {d_gnt, mem_wr, mem_wide}); end
      checks++; if (mem_din !== 16'h00AB) begin errors++; $display("FAIL nstore_din: got %h expected 00ab", mem_din); end
      @(negedge clk);
      set_d(1'b0, 1'b0, 1'b1, 16'h0103, 16'h0000);
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL nstore_no_rvalid: got %b expected 0", d_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL nload_s_rvalid: got %b expected 1", d_rvalid); end
      checks++; if (d_rdata !== 16'hFFAB) begin errors++; $display("FAIL nload_s_rdata: got %h expected ffab", d_rdata); end
      @(negedge clk);
      set_d(1'b0, 1'b0, 1'b0, 16'h0103, 16'h0000);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      checks++; if (d_rdata !== 16'h00AB) begin errors++; $display("FAIL nload_u_rdata: got %h expected 00ab", d_rdata); end
      @(negedge clk);
      set_d(1'b0, 1'b0, 1'b1, 16'h0102, 16'h0000);
      @(negedge clk);
      set_idle();
      @(negedge clk);
      #1;
      checks++; if (d_rdata !== 16'h0056) begin errors++; $display("FAIL nload_0102: got %h expected 0056", d_rdata); end
   endtask

   task automatic test_contention();
      logic exp_d [0:8];
      for (int k = 0; k < 9; k++) begin
`ifdef MEM_ARB_FAIR_EN
         exp_d[k] = ((k % 3) != 2);
`else
         exp_d[k] = 1'b1;
`endif
      end
      for (int k = 0; k < 11; k++) begin
         @(negedge clk);
         if (k < 9) begin
            f_req = 1'b1;
            f_addr = 16'h0100;
            set_d(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000);
         end else begin
            set_idle();
         end
         #1;
         if (k < 9) begin
            checks++; if (d_gnt !== exp_d[k]) begin errors++; $display("FAIL arb_d_gnt[%0d]: got %b expected %b", k, d_gnt, exp_d[k]); end
            checks++; if (f_gnt !== !exp_d[k]) begin errors++; $display("FAIL arb_f_gnt[%0d]: got %b expected %b", k, f_gnt, !exp_d[k]); end
         end
         if (k >= 2) begin
            checks++; if (d_rvalid !== exp_d[k-2]) begin errors++; $display("FAIL arb_d_rvalid[%0d]: got %b expected %b", k, d_rvalid, exp_d[k-2]); end
            checks++; if (f_rvalid !== !exp_d[k-2]) begin errors++; $display("FAIL arb_f_rvalid[%0d]: got %b expected %b", k, f_rvalid, !exp_d[k-2]); end
            if (exp_d[k-2]) begin
               checks++; if (d_rdata !== 16'h3456) begin errors++; $display("FAIL arb_d_rdata[%0d]: got %h expected 3456", k, d_rdata); end
            end else begin
               checks++; if (f_rdata !== 16'h1234) begin errors++; $display("FAIL arb_f_rdata[%0d]: got %h expected 1234", k, f_rdata); end
            end
         end else begin
            checks++; if ({d_rvalid, f_rvalid} !== 2'b00) begin errors++; $display("FAIL arb_early_rvalid[%0d]: got %b expected 00", k, {d_rvalid, f_rvalid}); end
         end
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      set_d(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000);
      @(negedge clk);
      set_d(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
      rst_n = 1'b0;
      #1;
      checks++; if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin errors++; $display("FAIL mid_rst_gnt: got %b expected 000", {f_gnt, d_gnt, mem_en}); end
      @(negedge clk);
      set_idle();
      #1;
      checks++; if ({f_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rst_rvalid: got %b expected 00", {f_rvalid, d_rvalid}); end
      checks++; if (d_rdata !== 16'h0000) begin errors++; $display("FAIL mid_rst_d_rdata: got %h expected 0000", d_rdata); end
      checks++; if (f_rdata !== 16'h0000) begin errors++; $display("FAIL mid_rst_f_rdata: got %h expected 0000", f_rdata); end
      checks++; if ({f_gnt, d_gnt, mem_en} !== 3'b000) begin errors++; $display("FAIL mid_rst_gnt2: got %b expected 000", {f_gnt, d_gnt, mem_en}); end
      for (int k = 3; k <= 5; k++) begin
         @(negedge clk);
         rst_n = 1'b1;
         #1;
         checks++; if ({f_rvalid, d_rvalid} !== 2'b00) begin errors++; $display("FAIL mid_rst_after[T+%0d]: got %b expected 00", k, {f_rvalid, d_rvalid}); end
      end
      @(negedge clk);
      set_d(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000);
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL post_rst_early: got %b expected 0", d_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL post_rst_rvalid: got %b expected 1", d_rvalid); end
      checks++; if (d_rdata !== 16'h0012) begin errors++; $display("FAIL post_rst_rdata: got %h expected 0012", d_rdata); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_d(1'b1, 1'b1, 1'b0, 16'h0200, 16'hBEEF);
      #1;
      checks++; if ({mem_en, mem_wr, mem_wide} !== 3'b111) begin errors++; $display("FAIL b2b_ctl: got %b expected 111", {mem_en, mem_wr, mem_wide}); end
      checks++; if (mem_din !== 16'hBEEF) begin errors++; $display("FAIL b2b_din: got %h expected beef", mem_din); end
      checks++; if (mem_addr !== 16'h0200) begin errors++; $display("FAIL b2b_addr: got %h expected 0200", mem_addr); end
      @(negedge clk);
      set_d(1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
      @(negedge clk);
      set_idle();
      #1;
      checks++; if (d_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_store_rvalid: got %b expected 0", d_rvalid); end
      @(negedge clk);
      #1;
      checks++; if (d_rvalid !== 1'b1) begin errors++; $display("FAIL b2b_rvalid: got %b expected 1", d_rvalid); end
      checks++; if (d_rdata !== 16'hBEEF) begin errors++; $display("FAIL b2b_rdata: got %h expected beef", d_rdata); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_wide_load();
      test_narrow();
      test_contention();
      test_reset_mid();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Upstream neighbour of the byte-addressed 16-bit memory. It arbitrates between the instruction-fetch port and the load/store data port, and drives the memory's en/wr/wide/addr/din.
- It captures the memory's synchronous read data and returns it to the winning requester, with byte extension for narrow loads.
- Fully pipelined: one access per cycle, fixed 2-cycle read latency.

Parameters:
- FAIR_LIMIT, 2: maximum consecutive data grants while fetch is waiting. Used only when MEM_ARB_FAIR_EN is defined. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active low
- f_req  in  1  fetch request; always a wide read; held with f_addr until f_gnt
- f_addr  in  16  fetch byte address
- f_gnt  out  1  combinational; fetch accepted this cycle
- f_rvalid  out  1  fetch read data valid (1-cycle pulse)
- f_rdata  out  16  fetch read data
- d_req  in  1  data request; held with d_* until d_gnt
- d_wr  in  1  1 = store, 0 = load
- d_wide  in  1  1 = 16-bit access, 0 = 8-bit access
- d_signed  in  1  narrow loads: 1 = sign-extend, 0 = zero-extend
- d_addr  in  16  data byte address
- d_wdata  in  16  store data; narrow stores use [7:0]
- d_gnt  out  1  combinational; data accepted this cycle
- d_rvalid  out  1  load data valid (1-cycle pulse); never pulses for stores
- d_rdata  out  16  load data
- mem_en, mem_wr, mem_wide  out  1 each  memory controls
- mem_addr  out  16  memory byte address
- mem_din  out  16  memory write data
- mem_dout  in  16  memory read data, valid the cycle after mem_en

Behaviour:
- Clock and reset: single clock domain, clk. Reset is synchronous, active-low, named rst_n.
- Reset: while rst_n=0, f_gnt, d_gnt and mem_en are forced 0. At the first edge with rst_n=0, all registered outputs clear: f_rvalid=d_rvalid=0, f_rdata=d_rdata=0, pipeline tags cleared, fairness counter=0.
- Grant in cycle T, without MEM_ARB_FAIR_EN: if d_req, grant data; else if f_req, grant fetch; else idle. At most one grant per cycle.
- Grant in cycle T drives the memory combinationally from the winner:
  - mem_en=1, mem_addr=winner address.
  - Data: mem_wr=d_wr, mem_wide=d_wide, mem_din=d_wdata.
  - Fetch: mem_wr=0, mem_wide=1.
  - Idle: mem_en=0, mem_wr=0; other memory outputs don't-care, held at the data-port values.
- Tag stage 1 (registered at the end of T): valid, port (F/D), is-read, wide, signed. Set only for reads.
- Stage 2 (registered at the end of T+1) from mem_dout:
  - Wide read: rdata = mem_dout.
  - Narrow read: byte = mem_dout[15:8]. d_rdata = d_signed ? {8{byte[7]}},byte : 8'h00,byte.
  - Result goes to the tagged port: rvalid=1 in T+2 and rdata held until that port's next response.
- Latency: grant T, data visible T+2. Throughput 1 access per cycle. Responses return in grant order.
- Stores complete at the end of T. A load granted in T+1 to the same address returns the new data.
- Endianness is big-endian:
  - Wide store to A writes d_wdata[15:8] to A and [7:0] to A+1.
  - Unaligned accesses are passed through unchanged.
  - Wide access at 0xFFFF wraps, pairing bytes 0xFFFF and 0x0000.
- Reset mid-operation: in-flight tags are discarded. No rvalid is produced for any access granted before or during reset.
- Requester rule: a requester must not change its request fields while req=1 and gnt=0. The arbiter does not check this.

Optional Feature:
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - 4-bit counter fcnt increments on each data grant while f_req=1.
  - fcnt resets to 0 on any fetch grant, or in any cycle with f_req=0.
  - When fcnt==FAIR_LIMIT and f_req=1, fetch wins that cycle even if d_req=1.
  - With both requesting continuously and FAIR_LIMIT=2, the grant pattern is D,D,F repeating.
- Not defined: strict data priority. No counter is built; fetch can starve indefinitely.

Test Plan:
- Preload bytes 0x0100=12, 0x0101=34, 0x0102=56. f_req with f_addr=0x0100 at T -> f_gnt=1 at T, f_rvalid=1 and f_rdata=0x1234 at T+2, d_rvalid=0 throughout.
- d_req wide load at 0x0101 -> d_rdata=0x3456. Preload 0xFFFF=9A and 0x0000=BC, wide load at 0xFFFF -> 0x9ABC.
- Narrow store d_addr=0x0103, d_wdata=0x00AB at T; narrow load 0x0103 with d_signed=1 at T+1 -> d_rdata=0xFFAB at T+3. Repeat with d_signed=0 -> 0x00AB. Byte 0x0102 still reads 0x56.
- f_req=d_req=1 held for 9 cycles, all loads:
  - Macro off -> d_gnt every cycle, f_gnt never.
  - Macro on, FAIR_LIMIT=2 -> grant order D,D,F,D,D,F,D,D,F, with responses in the same order 2 cycles later.
- Issue loads at T and T+1, drive rst_n=0 at T+1 for 2 cycles -> no rvalid at any cycle T+2..T+5, all outputs 0 during reset. First load after reset returns correct data with 2-cycle latency.
- Back-to-back: wide store 0xBEEF to 0x0200 at T, wide load 0x0200 at T+1 -> d_rvalid at T+3 with 0xBEEF. No d_rvalid at T+2 for the store.
